// File: rtl/seg_scan_capture.sv
// seg_scan_capture: passive receiver for a multiplexed 6-digit seven-segment bus.
// Waits for each scanned digit to settle, then decodes its segment pattern back to a
// hex nibble. Assembles complete frames and publishes the 24-bit value once
// STABLE_FRAMES identical, error-free frames have been seen in a row.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   seg_nCS      digit select, active-low one-hot; bit i selects digit i (digit 0 = LS nibble)
//   seg_leds     segments [6:0] = g,f,e,d,c,b,a ; [7] = dp
//   number       last published value {d5..d0}
//   dp           decimal-point state per digit from the published frame
//   blank_mask   digits that were dark (segments 0) in the published frame
//   number_valid one-cycle pulse when number/dp/blank_mask are loaded
//   frame_err    one-cycle pulse when a completed frame held an undecodable pattern
module seg_scan_capture #(
  parameter int unsigned SETTLE         = 16,
  parameter int unsigned STABLE_FRAMES  = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  seg_nCS,
  input  logic [7:0]  seg_leds,
  output logic [23:0] number,
  output logic [5:0]  dp,
  output logic [5:0]  blank_mask,
  output logic        number_valid,
  output logic        frame_err
);

  localparam int unsigned CntW   = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam int unsigned MatchW = (STABLE_FRAMES > 1) ? $clog2(STABLE_FRAMES + 1) : 1;

  typedef enum logic [1:0] {StWaitSel, StSettle, StHold} state_e;

  // Two-stage input registers; stage 3 is the previous registered copy for change detect.
  logic [5:0]  ncs_s1_q, ncs_s2_q, ncs_s3_q;
  logic [7:0]  leds_s1_q, leds_s2_q, leds_s3_q;

  state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [5:0]  seen_q, seen_d;
  logic [5:0]  bad_q, bad_d;
  logic [23:0] shadow_num_q, shadow_num_d;
  logic [5:0]  shadow_dp_q, shadow_dp_d;
  logic [5:0]  shadow_blank_q, shadow_blank_d;

  logic [23:0] prev_num_q, prev_num_d;
  logic [5:0]  prev_dp_q, prev_dp_d;
  logic [5:0]  prev_blank_q, prev_blank_d;
  logic [MatchW-1:0] match_q, match_d;
  logic        pub_valid_q, pub_valid_d;

  logic [23:0] number_q, number_d;
  logic [5:0]  dp_q, dp_d;
  logic [5:0]  blank_q, blank_d;
  logic        number_valid_q, number_valid_d;
  logic        frame_err_q, frame_err_d;

  // Returns {valid, nibble}; blank (0x00) is handled by the caller.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    r = 5'h00;
    case (s)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h7C: r = {1'b1, 4'hB};
      7'h39: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [5:0] sel;
  logic       sel_ok;
  logic [2:0] slot;
  logic       changed;
  logic       capture;
  logic [7:0] pat;
  logic [4:0] dec;
  logic       is_blank;

  assign sel      = ~ncs_s2_q;
  assign sel_ok   = (sel != 6'd0) && ((sel & (sel - 6'd1)) == 6'd0);
  assign changed  = (ncs_s2_q != ncs_s3_q) || (leds_s2_q != leds_s3_q);
  assign pat      = SEG_ACTIVE_LOW ? ~leds_s2_q : leds_s2_q;
  assign dec      = seg_decode(pat[6:0]);
  assign is_blank = (pat[6:0] == 7'h00);

  always_comb begin
    slot = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (sel[i]) slot = 3'(i);
    end
  end

  // Scan FSM: one capture per select dwell, after SETTLE unchanged cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      StWaitSel: begin
        cnt_d = '0;
        if (sel_ok) state_d = StSettle;
      end
      StSettle: begin
        if (!sel_ok) begin
          state_d = StWaitSel;
          cnt_d   = '0;
        end else if (changed) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(SETTLE - 1)) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (ncs_s2_q != ncs_s3_q) state_d = StWaitSel;
      end
      default: state_d = StWaitSel;
    endcase
  end

  // Capture into the shadow frame and evaluate completed frames.
  logic              frame_done;
  logic              same_prev;
  logic              same_pub;
  logic [MatchW-1:0] match_new;

  always_comb begin
    seen_d         = seen_q;
    bad_d          = bad_q;
    shadow_num_d   = shadow_num_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    prev_num_d     = prev_num_q;
    prev_dp_d      = prev_dp_q;
    prev_blank_d   = prev_blank_q;
    match_d        = match_q;
    pub_valid_d    = pub_valid_q;
    number_d       = number_q;
    dp_d           = dp_q;
    blank_d        = blank_q;
    number_valid_d = 1'b0;
    frame_err_d    = 1'b0;
    match_new      = match_q;

    frame_done = (seen_q == 6'h3F);
    same_prev  = ({shadow_num_q, shadow_dp_q, shadow_blank_q} ==
                  {prev_num_q, prev_dp_q, prev_blank_q});
    same_pub   = ({shadow_num_q, shadow_dp_q, shadow_blank_q} ==
                  {number_q, dp_q, blank_q});

    if (capture) begin
      seen_d[slot]                    = 1'b1;
      bad_d[slot]                     = !(is_blank || dec[4]);
      shadow_num_d[{slot, 2'b00} +: 4] = is_blank ? 4'h0 : dec[3:0];
      shadow_dp_d[slot]               = pat[7];
      shadow_blank_d[slot]            = is_blank;
    end

    if (frame_done) begin
      seen_d = '0;
      bad_d  = '0;
      if (|bad_q) begin
        frame_err_d = 1'b1;
        match_d     = '0;
      end else begin
        if (same_prev) begin
          match_new = (match_q >= MatchW'(STABLE_FRAMES)) ? match_q : match_q + MatchW'(1);
        end else begin
          match_new    = MatchW'(1);
          prev_num_d   = shadow_num_q;
          prev_dp_d    = shadow_dp_q;
          prev_blank_d = shadow_blank_q;
        end
        match_d = match_new;
        if ((match_new == MatchW'(STABLE_FRAMES)) && (!pub_valid_q || !same_pub)) begin
          number_d       = shadow_num_q;
          dp_d           = shadow_dp_q;
          blank_d        = shadow_blank_q;
          number_valid_d = 1'b1;
          pub_valid_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ncs_s1_q       <= '1;
      ncs_s2_q       <= '1;
      ncs_s3_q       <= '1;
      leds_s1_q      <= '0;
      leds_s2_q      <= '0;
      leds_s3_q      <= '0;
      state_q        <= StWaitSel;
      cnt_q          <= '0;
      seen_q         <= '0;
      bad_q          <= '0;
      shadow_num_q   <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      prev_num_q     <= '0;
      prev_dp_q      <= '0;
      prev_blank_q   <= '0;
      match_q        <= '0;
      pub_valid_q    <= 1'b0;
      number_q       <= '0;
      dp_q           <= '0;
      blank_q        <= '0;
      number_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      ncs_s1_q       <= seg_nCS;
      ncs_s2_q       <= ncs_s1_q;
      ncs_s3_q       <= ncs_s2_q;
      leds_s1_q      <= seg_leds;
      leds_s2_q      <= leds_s1_q;
      leds_s3_q      <= leds_s2_q;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      seen_q         <= seen_d;
      bad_q          <= bad_d;
      shadow_num_q   <= shadow_num_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      prev_num_q     <= prev_num_d;
      prev_dp_q      <= prev_dp_d;
      prev_blank_q   <= prev_blank_d;
      match_q        <= match_d;
      pub_valid_q    <= pub_valid_d;
      number_q       <= number_d;
      dp_q           <= dp_d;
      blank_q        <= blank_d;
      number_valid_q <= number_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign number       = number_q;
  assign dp           = dp_q;
  assign blank_mask   = blank_q;
  assign number_valid = number_valid_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: drives whole scan frames and predicts, per frame, what the
// monitor must publish using a frame-level model of the decode/stability rules.
module tb_seg_scan_capture;

  localparam int STABLE = 2;
  localparam int DWELL  = 200;

  typedef logic [7:0] pats_t [6];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  seg_nCS = 6'h3F;
  logic [7:0]  seg_leds = 8'h00;
  logic [23:0] number;
  logic [5:0]  dp;
  logic [5:0]  blank_mask;
  logic        number_valid;
  logic        frame_err;

  always #10 clk = ~clk;

  seg_scan_capture #(
    .SETTLE        (16),
    .STABLE_FRAMES (2),
    .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_nCS     (seg_nCS),
    .seg_leds    (seg_leds),
    .number      (number),
    .dp          (dp),
    .blank_mask  (blank_mask),
    .number_valid(number_valid),
    .frame_err   (frame_err)
  );

  logic [6:0] seg_tab [16];

  int checks = 0;
  int failures = 0;

  // Model state (frame level)
  logic [23:0] m_num = '0, m_prev_num = '0, p_num = '0;
  logic [5:0]  m_dp = '0, m_blank = '0, m_prev_dp = '0, m_prev_blank = '0;
  logic [5:0]  p_dp = '0, p_blank = '0;
  bit          m_pub_valid = 1'b0;
  bit          p_pulse = 1'b0;
  int          m_match = 0;
  int          exp_valid = 0, exp_err = 0;
  int          obs_valid = 0, obs_err = 0;
  bit          eval_win = 1'b0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (number_valid) obs_valid++;
      if (frame_err) obs_err++;
      if (!eval_win)
        check("idle_outputs", {number, dp, blank_mask, number_valid, frame_err},
              {m_num, m_dp, m_blank, 2'b00});
      else if (number_valid)
        check("publish_values", {number, dp, blank_mask}, {p_num, p_dp, p_blank});
    end
  end

  task automatic mk_pats(input logic [23:0] v, input logic [5:0] dpm, input logic [5:0] blk,
                         output pats_t p);
    for (int d = 0; d < 6; d++)
      p[d] = {dpm[d], blk[d] ? 7'h00 : seg_tab[v[4*d +: 4]]};
  endtask

  // Decode a frame by table lookup and apply the stability rules.
  task automatic predict(input pats_t p);
    logic [23:0] n;
    logic [5:0]  ndp, nbl;
    logic [6:0]  s;
    bit          bad, found;
    n = '0; ndp = '0; nbl = '0; bad = 1'b0;
    for (int d = 0; d < 6; d++) begin
      s      = p[d][6:0];
      ndp[d] = p[d][7];
      nbl[d] = (s == 7'h00);
      found  = (s == 7'h00);
      for (int k = 0; k < 16; k++) begin
        if (seg_tab[k] == s) begin
          n[4*d +: 4] = k[3:0];
          found = 1'b1;
        end
      end
      if (!found) bad = 1'b1;
    end
    p_pulse = 1'b0;
    if (bad) begin
      exp_err++;
      m_match = 0;
    end else begin
      if ({n, ndp, nbl} == {m_prev_num, m_prev_dp, m_prev_blank}) begin
        if (m_match < STABLE) m_match++;
      end else begin
        m_match = 1;
        m_prev_num = n; m_prev_dp = ndp; m_prev_blank = nbl;
      end
      if (m_match == STABLE && (!m_pub_valid || {n, ndp, nbl} != {m_num, m_dp, m_blank})) begin
        p_pulse = 1'b1;
        p_num = n; p_dp = ndp; p_blank = nbl;
        exp_valid++;
      end
    end
  endtask

  task automatic scan_frame(input pats_t p, input bit glitch);
    predict(p);
    for (int d = 0; d < 6; d++) begin
      if (d == 5) eval_win = 1'b1;
      for (int c = 0; c < DWELL; c++) begin
        @(posedge clk); #1;
        seg_nCS  = ~(6'b000001 << d);
        seg_leds = (glitch && c == 2) ? 8'h49 : p[d];
      end
    end
    if (p_pulse) begin
      m_num = p_num; m_dp = p_dp; m_blank = p_blank;
      m_pub_valid = 1'b1;
    end
    eval_win = 1'b0;
    check("valid_pulses", obs_valid, exp_valid);
    check("err_pulses", obs_err, exp_err);
  endtask

  pats_t pa;

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_number", number, 24'h0);
    check("rst_dp", dp, 6'h0);
    check("rst_blank", blank_mask, 6'h0);
    check("rst_pulses", {number_valid, frame_err}, 2'b00);
    rst = 1'b0;
    chk_en = 1'b1;

    // Static 332002: publish once after frame 2, never again
    mk_pats(24'h332002, 6'h00, 6'h00, pa);
    scan_frame(pa, 1'b0);
    check("t1_f1_no_pulse", obs_valid, 0);
    scan_frame(pa, 1'b0);
    check("t1_f2_pulse", obs_valid, 1);
    check("t1_number", number, 24'h332002);
    check("t1_dp_blank", {dp, blank_mask}, 12'h000);
    scan_frame(pa, 1'b0);
    check("t1_f3_no_pulse", obs_valid, 1);

    // Value change needs two frames of the new value
    mk_pats(24'h0C0400, 6'h00, 6'h00, pa);
    scan_frame(pa, 1'b0);
    scan_frame(pa, 1'b0);
    check("t2_first", number, 24'h0C0400);
    mk_pats(24'h0C0401, 6'h00, 6'h00, pa);
    scan_frame(pa, 1'b0);
    check("t2_mid_no_pulse", obs_valid, 2);
    check("t2_mid_number", number, 24'h0C0400);
    scan_frame(pa, 1'b0);
    check("t2_second", number, 24'h0C0401);
    check("t2_pulses", obs_valid, 3);

    // Undecodable digit 3, then clean frames with a blank digit and a dp
    mk_pats(24'h0BCDEF, 6'b000010, 6'b100000, pa);
    pa[3] = 8'h49;
    scan_frame(pa, 1'b0);
    check("t3_err", obs_err, 1);
    check("t3_unchanged", number, 24'h0C0401);
    mk_pats(24'h0BCDEF, 6'b000010, 6'b100000, pa);
    scan_frame(pa, 1'b0);
    scan_frame(pa, 1'b0);
    check("t3_number", number, 24'h0BCDEF);
    check("t3_blank", blank_mask, 6'b100000);
    check("t3_dp", dp, 6'b000010);

    // Glitch two cycles after every select edge must never be captured
    mk_pats(24'h332002, 6'h00, 6'h00, pa);
    scan_frame(pa, 1'b1);
    scan_frame(pa, 1'b1);
    check("t4_number", number, 24'h332002);
    check("t4_no_err", obs_err, 1);

    // Illegal selects: nothing captured
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      seg_nCS  = (c < 500) ? 6'b111111 : 6'b110011;
      seg_leds = 8'h3F;
    end
    check("t5_no_pulse", obs_valid, 5);
    mk_pats(24'h0C0400, 6'h00, 6'h00, pa);
    scan_frame(pa, 1'b0);
    scan_frame(pa, 1'b0);
    check("t5_number", number, 24'h0C0400);

    // Reset in the middle of frame 2
    mk_pats(24'h332002, 6'h00, 6'h00, pa);
    scan_frame(pa, 1'b0);
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < ((d == 2) ? 50 : DWELL); c++) begin
        @(posedge clk); #1;
        seg_nCS  = ~(6'b000001 << d);
        seg_leds = pa[d];
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    seg_nCS = 6'h3F;
    seg_leds = 8'h00;
    m_num = '0; m_dp = '0; m_blank = '0; m_pub_valid = 1'b0;
    m_match = 0; m_prev_num = '0; m_prev_dp = '0; m_prev_blank = '0;
    @(posedge clk); #1;
    check("t6_rst_number", number, 24'h0);
    check("t6_rst_dp_blank", {dp, blank_mask}, 12'h000);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    scan_frame(pa, 1'b0);
    check("t6_f1_no_pulse", obs_valid, 6);
    check("t6_f1_number", number, 24'h0);
    scan_frame(pa, 1'b0);
    check("t6_f2_pulse", obs_valid, 7);
    check("t6_number", number, 24'h332002);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
